gb_csr_responder: RTL and testbench
===================================

Name: gb_csr_responder

Overview:
- Ghostbus target (responder): the far end of the gb_addr/gb_wdata/gb_wen/gb_rstb/gb_rdata bus that testbenches and localbus hosts drive as initiator.
- Decodes a 64-word window at BASE and serves:
  - NCSR read/write control registers;
  - read-only ID, write-counter and status words;
  - an optional small RAM.
- Returns read data at a fixed latency of READ_DELAY cycles after the read strobe.
- Drives zero when not returning data, so several instances can be OR-combined onto one gb_rdata.

Parameters:
AW, 24, address width
DW, 32, data width
BASE, 24'h000000, window base; must be 64-word aligned
NCSR, 4, number of RW CSRs; power of 2, 1..16
RAM_AW, 3, RAM address width, 1..5
READ_DELAY, 3, gb_rstb-to-gb_rdata latency in cycles, >=1
ID_VAL, 32'h6B0B_0001, constant returned at the ID word

Ports:
gb_clk  in  1  bus clock; all logic on rising edge
gb_rst_n  in  1  asynchronous active-low reset
gb_addr  in  AW  word address
gb_wdata  in  DW  write data
gb_wen  in  1  write strobe, one cycle per write
gb_rstb  in  1  read strobe, one cycle per read
gb_rdata  out  DW  read data; zero except in the response cycle
csr_out  out  NCSR*DW  CSR contents; CSR k at bits [k*DW +: DW]
csr_we  out  NCSR  one-cycle pulse when CSR k is written
status_in  in  DW  live status, readable at offset 0x12

Behaviour:
- Hit: gb_addr[AW-1:6] == BASE[AW-1:6]; offset = gb_addr[5:0].
- Map by offset:
  - 0..NCSR-1: RW CSRs.
  - 0x10: ID_VAL (RO).
  - 0x11: wcnt (RO).
  - 0x12: status_in (RO).
  - 0x20..0x20+2^RAM_AW-1: RAM.
  - All other offsets read 0; writes to them are ignored.
- Reset (async assert; release synchronous to gb_clk):
  - csr_out = 0, csr_we = 0, wcnt = 0, gb_rdata = 0.
  - Read pipeline valid bits cleared.
  - RAM contents are not reset.
- Write (gb_wen & hit, sampled at edge T):
  - CSR/RAM updated at edge T; csr_we[k] high for the cycle after T.
  - wcnt increments on every accepted write to any mapped RW location; it wraps at 2^DW.
  - Writes to RO offsets do not increment wcnt.
- Read (gb_rstb & hit, sampled at edge T):
  - Stage 1 registers the muxed data; the RAM is synchronous-read in this stage.
  - READ_DELAY-1 further stages carry {valid, data}.
  - gb_rdata = data for exactly one cycle, from edge T+READ_DELAY; otherwise 0.
- Back-to-back reads on consecutive cycles are fully pipelined; each returns in order at fixed latency.
- gb_wen and gb_rstb in the same cycle, same address: the write is applied and the read returns the pre-write value.
- Read miss (not hit): no valid is launched; gb_rdata stays 0.
- Reset asserted mid-read: the pipeline is flushed and no response emerges after release.
- gb_wen and gb_rstb are single-cycle strobes; this block does not back-pressure.
- gb_addr and gb_wdata are sampled only on strobe cycles.

Optional Feature:
- Macro GB_CSR_RESPONDER_RAM_EN.
- Defined: the 2^RAM_AW x DW RAM exists at offsets 0x20+, written as described above, with synchronous read.
- Undefined: no RAM is inferred; RAM offsets read 0, writes to them are ignored and do not increment wcnt.
- Latency is identical in both builds.

Decomposition:
- Package gb_resp_pkg holds:
  - offset constants OFF_ID = 6'h10, OFF_WCNT = 6'h11, OFF_STATUS = 6'h12, OFF_RAM = 6'h20;
  - WINDOW_AW = 6.
- Sub-module gb_rdata_pipe: a parameterised {valid, data} delay line of depth READ_DELAY-1 with async reset of valid, outputting data gated by valid.
- The decoder, CSRs, counter and RAM stay in the top module.

Test Plan:
- Reset, then read offsets 0..3, 0x10, 0x11 -> 0, 0, 0, 0, 32'h6B0B0001, 0, each at exactly T+3; gb_rdata is 0 in every other cycle.
- Write 32'hA5A5_0000+k to CSR k (k = 0..3), then read each back -> values match; csr_we[k] pulses one cycle after each write; wcnt reads 4.
- Read offsets 0,1,2,3 on four consecutive cycles -> responses appear on four consecutive cycles in order, starting at T+3.
- Same cycle: write 32'h1234 to CSR0 and read CSR0 (CSR0 previously 32'hA5A50000) -> read returns 32'hA5A50000; the next read returns 32'h1234.
- Read gb_addr = BASE+64 (miss), and write to offset 0x10 -> gb_rdata stays 0; ID is unchanged; wcnt is unchanged.
- Assert gb_rst_n low one cycle after a read strobe -> no response after release; csr_out = 0.
- With GB_CSR_RESPONDER_RAM_EN defined: write 0xE8..0xEF to RAM, then read back -> match. Without the macro -> reads return 0.

Source files
------------

// File: rtl/gb_resp_pkg.sv
// Shared constants for the ghostbus CSR responder: window size and fixed word offsets.
package gb_resp_pkg;

    localparam int unsigned WINDOW_AW = 6;

    localparam logic [WINDOW_AW-1:0] OFF_ID     = 6'h10;
    localparam logic [WINDOW_AW-1:0] OFF_WCNT   = 6'h11;
    localparam logic [WINDOW_AW-1:0] OFF_STATUS = 6'h12;
    localparam logic [WINDOW_AW-1:0] OFF_RAM    = 6'h20;

endpackage

// File: rtl/gb_rdata_pipe.sv
// {valid, data} delay line of DEPTH stages followed by a registered, valid-gated output
// so the bus sees zero whenever no response is due.
module gb_rdata_pipe #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_valid,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data
);

    logic [DEPTH:0] w_valid;
    logic [DW-1:0]  w_data [DEPTH+1];
    logic [DW-1:0]  r_out;

    assign w_valid[0] = i_valid;
    assign w_data[0]  = i_data;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic          r_valid;
        logic [DW-1:0] r_data;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= w_valid[g];
            end
        end

        always_ff @(posedge i_clk) begin
            if (w_valid[g]) begin
                r_data <= w_data[g];
            end
        end

        assign w_valid[g+1] = r_valid;
        assign w_data[g+1]  = r_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out <= '0;
        end else begin
            r_out <= w_valid[DEPTH] ? w_data[DEPTH] : '0;
        end
    end

    assign o_data = r_out;

endmodule

// File: rtl/gb_csr_responder.sv
// Ghostbus responder: 64-word window with RW CSRs, ID/write-count/status words and an
// optional RAM (enabled by GB_CSR_RESPONDER_RAM_EN); reads return after READ_DELAY cycles.
module gb_csr_responder
    import gb_resp_pkg::*;
#(
    parameter int unsigned   AW         = 24,
    parameter int unsigned   DW         = 32,
    parameter logic [AW-1:0] BASE       = '0,
    parameter int unsigned   NCSR       = 4,
    parameter int unsigned   RAM_AW     = 3,
    parameter int unsigned   READ_DELAY = 3,
    parameter logic [DW-1:0] ID_VAL     = 32'h6B0B_0001
) (
    input  logic               gb_clk,
    input  logic               gb_rst_n,
    input  logic [AW-1:0]      gb_addr,
    input  logic [DW-1:0]      gb_wdata,
    input  logic               gb_wen,
    input  logic               gb_rstb,
    output logic [DW-1:0]      gb_rdata,
    output logic [NCSR*DW-1:0] csr_out,
    output logic [NCSR-1:0]    csr_we,
    input  logic [DW-1:0]      status_in
);

`ifdef GB_CSR_RESPONDER_RAM_EN
    localparam bit RAM_EN = 1'b1;
`else
    localparam bit RAM_EN = 1'b0;
`endif

    logic                 w_hit;
    logic [WINDOW_AW-1:0] w_off;
    logic                 w_wr;
    logic                 w_rd;
    logic                 w_ram_hit;
    logic                 w_wr_ram;
    logic                 w_wr_any;
    logic [NCSR-1:0]      w_csr_wr;
    logic [DW-1:0]        w_rd_mux;
    logic [DW-1:0]        w_s1_data;

    logic [DW-1:0]        r_csr [NCSR];
    logic [NCSR-1:0]      r_csr_we;
    logic [DW-1:0]        r_wcnt;
    logic                 r_s1_valid;
    logic [DW-1:0]        r_s1_data;

    assign w_hit     = gb_addr[AW-1:WINDOW_AW] == BASE[AW-1:WINDOW_AW];
    assign w_off     = gb_addr[WINDOW_AW-1:0];
    assign w_wr      = gb_wen & w_hit;
    assign w_rd      = gb_rstb & w_hit;
    // Constant-false without the RAM, so RAM offsets fall through to the unmapped path.
    assign w_ram_hit = RAM_EN && ((w_off >> RAM_AW) == (OFF_RAM >> RAM_AW));
    assign w_wr_ram  = w_wr & w_ram_hit;
    assign w_wr_any  = (|w_csr_wr) | w_wr_ram;

    always_comb begin
        w_csr_wr = '0;
        for (int k = 0; k < NCSR; k++) begin
            if (w_wr && (w_off == WINDOW_AW'(k))) begin
                w_csr_wr[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            for (int k = 0; k < NCSR; k++) begin
                r_csr[k] <= '0;
            end
            r_csr_we <= '0;
            r_wcnt   <= '0;
        end else begin
            for (int k = 0; k < NCSR; k++) begin
                if (w_csr_wr[k]) begin
                    r_csr[k] <= gb_wdata;
                end
            end
            r_csr_we <= w_csr_wr;
            if (w_wr_any) begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < NCSR; k++) begin
            if (w_off == WINDOW_AW'(k)) begin
                w_rd_mux = r_csr[k];
            end
        end
        case (w_off)
            OFF_ID:     w_rd_mux = ID_VAL;
            OFF_WCNT:   w_rd_mux = r_wcnt;
            OFF_STATUS: w_rd_mux = status_in;
            default:    ;
        endcase
    end

    // Stage 1: register values as seen before this edge's write, giving read-before-write.
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_rd;
        end
    end

    always_ff @(posedge gb_clk) begin
        if (w_rd) begin
            r_s1_data <= w_rd_mux;
        end
    end

`ifdef GB_CSR_RESPONDER_RAM_EN
    localparam int unsigned RAM_DEPTH = 2 ** RAM_AW;

    logic [DW-1:0]     r_ram [RAM_DEPTH];
    logic [DW-1:0]     r_ram_q;
    logic              r_s1_ram;
    logic [RAM_AW-1:0] w_ram_idx;

    assign w_ram_idx = w_off[RAM_AW-1:0];

    always_ff @(posedge gb_clk) begin
        if (w_wr_ram) begin
            r_ram[w_ram_idx] <= gb_wdata;
        end
        if (w_rd) begin
            r_ram_q  <= r_ram[w_ram_idx];
            r_s1_ram <= w_ram_hit;
        end
    end

    assign w_s1_data = r_s1_ram ? r_ram_q : r_s1_data;
`else
    assign w_s1_data = r_s1_data;
`endif

    gb_rdata_pipe #(
        .DW    (DW),
        .DEPTH (READ_DELAY - 1)
    ) u_rdata_pipe (
        .i_clk   (gb_clk),
        .i_rst_n (gb_rst_n),
        .i_valid (r_s1_valid),
        .i_data  (w_s1_data),
        .o_data  (gb_rdata)
    );

    for (genvar k = 0; k < NCSR; k++) begin : g_csr_out
        assign csr_out[k*DW +: DW] = r_csr[k];
    end

    assign csr_we = r_csr_we;

endmodule

// File: tb/tb_gb_csr_responder.sv
// Directed self-checking bench for gb_csr_responder with the default parameter set.
module tb_gb_csr_responder;

    localparam int AW   = 24;
    localparam int DW   = 32;
    localparam int NCSR = 4;
    localparam logic [31:0] ID = 32'h6B0B_0001;

`ifdef GB_CSR_RESPONDER_RAM_EN
    localparam bit RAM_EN = 1'b1;
`else
    localparam bit RAM_EN = 1'b0;
`endif

    logic               gb_clk = 1'b0;
    logic               gb_rst_n = 1'b0;
    logic [AW-1:0]      gb_addr = '0;
    logic [DW-1:0]      gb_wdata = '0;
    logic               gb_wen = 1'b0;
    logic               gb_rstb = 1'b0;
    logic [DW-1:0]      gb_rdata;
    logic [NCSR*DW-1:0] csr_out;
    logic [NCSR-1:0]    csr_we;
    logic [DW-1:0]      status_in = 32'hC0FF_EE01;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 gb_clk = ~gb_clk;

    gb_csr_responder u_dut (
        .gb_clk    (gb_clk),
        .gb_rst_n  (gb_rst_n),
        .gb_addr   (gb_addr),
        .gb_wdata  (gb_wdata),
        .gb_wen    (gb_wen),
        .gb_rstb   (gb_rstb),
        .gb_rdata  (gb_rdata),
        .csr_out   (csr_out),
        .csr_we    (csr_we),
        .status_in (status_in)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge gb_clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [NCSR-1:0] exp_we);
        gb_addr  = a;
        gb_wdata = d;
        gb_wen   = 1'b1;
        tick();
        gb_wen = 1'b0;
        check("csr_we_pulse", 128'(csr_we), 128'(exp_we));
        tick();
        check("csr_we_clear", 128'(csr_we), 128'(0));
    endtask

    // Strobe at edge T; data must show only in the cycle after edge T+3.
    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        gb_addr = a;
        gb_rstb = 1'b1;
        tick();
        gb_rstb = 1'b0;
        check({tag, "_t0"}, 128'(gb_rdata), 128'(0));
        tick();
        check({tag, "_t1"}, 128'(gb_rdata), 128'(0));
        tick();
        check({tag, "_t2"}, 128'(gb_rdata), 128'(0));
        tick();
        check({tag, "_t3"}, 128'(gb_rdata), 128'(exp));
        tick();
        check({tag, "_t4"}, 128'(gb_rdata), 128'(0));
    endtask

    initial begin
        repeat (2) tick();
        check("rst_rdata", 128'(gb_rdata), 128'(0));
        check("rst_csr_out", 128'(csr_out), 128'(0));
        check("rst_csr_we", 128'(csr_we), 128'(0));
        gb_rst_n = 1'b1;
        tick();

        do_read("rd_csr0", 24'h00, 32'h0);
        do_read("rd_csr1", 24'h01, 32'h0);
        do_read("rd_csr2", 24'h02, 32'h0);
        do_read("rd_csr3", 24'h03, 32'h0);
        do_read("rd_id", 24'h10, ID);
        do_read("rd_wcnt0", 24'h11, 32'h0);
        do_read("rd_status", 24'h12, 32'hC0FF_EE01);

        for (int k = 0; k < NCSR; k++) begin
            do_write(AW'(k), 32'hA5A5_0000 + 32'(k), NCSR'(1 << k));
        end
        check("csr_out_wr", 128'(csr_out),
              {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000});
        do_read("rb_csr0", 24'h00, 32'hA5A5_0000);
        do_read("rb_csr1", 24'h01, 32'hA5A5_0001);
        do_read("rb_csr2", 24'h02, 32'hA5A5_0002);
        do_read("rb_csr3", 24'h03, 32'hA5A5_0003);
        do_read("rd_wcnt4", 24'h11, 32'd4);

        // Four strobes on consecutive edges; responses must be consecutive and in order.
        gb_rstb = 1'b1;
        gb_addr = 24'h00;
        tick();
        gb_addr = 24'h01;
        tick();
        gb_addr = 24'h02;
        tick();
        gb_addr = 24'h03;
        tick();
        gb_rstb = 1'b0;
        check("pipe_r0", 128'(gb_rdata), 128'(32'hA5A5_0000));
        tick();
        check("pipe_r1", 128'(gb_rdata), 128'(32'hA5A5_0001));
        tick();
        check("pipe_r2", 128'(gb_rdata), 128'(32'hA5A5_0002));
        tick();
        check("pipe_r3", 128'(gb_rdata), 128'(32'hA5A5_0003));
        tick();
        check("pipe_idle", 128'(gb_rdata), 128'(0));

        // Simultaneous write and read of CSR0: read returns the old value.
        gb_addr  = 24'h00;
        gb_wdata = 32'h0000_1234;
        gb_wen   = 1'b1;
        gb_rstb  = 1'b1;
        tick();
        gb_wen  = 1'b0;
        gb_rstb = 1'b0;
        check("rw_we", 128'(csr_we), 128'(1));
        check("rw_t0", 128'(gb_rdata), 128'(0));
        tick();
        check("rw_t1", 128'(gb_rdata), 128'(0));
        tick();
        check("rw_t2", 128'(gb_rdata), 128'(0));
        tick();
        check("rw_old", 128'(gb_rdata), 128'(32'hA5A5_0000));
        tick();
        check("rw_t4", 128'(gb_rdata), 128'(0));
        do_read("rw_new", 24'h00, 32'h0000_1234);

        // Misses and RO writes leave state and the counter alone.
        do_read("miss_rd", 24'h40, 32'h0);
        do_write(24'h40, 32'hFFFF_FFFF, 4'b0000);
        do_write(24'h10, 32'hDEAD_BEEF, 4'b0000);
        do_read("id_kept", 24'h10, ID);
        do_read("csr0_kept", 24'h00, 32'h0000_1234);
        do_read("rd_wcnt5", 24'h11, 32'd5);
        do_read("unmapped", 24'h13, 32'h0);

        // Reset one cycle after a read strobe: the response must never appear.
        gb_addr = 24'h10;
        gb_rstb = 1'b1;
        tick();
        gb_rstb = 1'b0;
        tick();
        gb_rst_n = 1'b0;
        #2;
        check("rst_mid_rdata", 128'(gb_rdata), 128'(0));
        tick();
        tick();
        gb_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rst_flush", 128'(gb_rdata), 128'(0));
            tick();
        end
        check("rst_csr_clr", 128'(csr_out), 128'(0));
        do_read("rd_wcnt_rst", 24'h11, 32'h0);

        for (int i = 0; i < 8; i++) begin
            do_write(24'h20 + AW'(i), 32'hE8 + 32'(i), 4'b0000);
        end
        for (int i = 0; i < 8; i++) begin
            do_read("ram_rb", 24'h20 + AW'(i), RAM_EN ? 32'hE8 + 32'(i) : 32'h0);
        end
        do_read("ram_past_end", 24'h28, 32'h0);
        do_read("rd_wcnt_ram", 24'h11, RAM_EN ? 32'd8 : 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
